// File: rtl/bottom_output_bus.sv
// Bottom-edge collector: stores column-skewed PE results per column and replays aligned tiles.
// Optional arrival-skew checker is enabled by defining OUTBUS_SKEW_CHECK_EN.
module bottom_output_bus #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned K_ADDR_LEN = 7,
    parameter int unsigned LOOP_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          Mode,
    input  logic [K_ADDR_LEN-1:0]               K_len,
    input  logic [LOOP_WIDTH-1:0]               Loop_num,
    input  logic [NUM_COLS-1:0][LANES*DW-1:0]   PE_bot_data,
    input  logic [NUM_COLS-1:0]                 PE_bot_valid,
    output logic [NUM_COLS-1:0][LANES*DW-1:0]   Out_data,
    output logic                                Out_valid,
    input  logic                                Out_ready,
    output logic                                streaming_drain_done,
    output logic                                overflow_err,
    output logic                                skew_err
);
    localparam int unsigned VW    = LANES * DW;
    localparam int unsigned DEPTH = 2 ** K_ADDR_LEN;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_e;

    state_e                  state_q;
    logic [K_ADDR_LEN-1:0]   k_len_q;
    logic [K_ADDR_LEN-1:0]   rd_idx_q;
    logic [K_ADDR_LEN-1:0]   fill_q [NUM_COLS];
    logic [LOOP_WIDTH-1:0]   loop_num_q;
    logic [LOOP_WIDTH-1:0]   loop_cnt_q;
    logic                    done_q;
    logic                    overflow_q;
    logic [VW-1:0]           col_ram [NUM_COLS][DEPTH];

    logic [NUM_COLS-1:0]     wr_en;
    logic [NUM_COLS-1:0]     col_full;
    logic                    stream_mode;
    logic                    all_full;
    logic                    handshake;
    logic                    last_beat;
    logic                    overflow_set;

    // Write enables, fill status and drain handshake decode
    always_comb begin
        stream_mode = (Mode == 2'b00);
        wr_en       = '0;
        col_full    = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            col_full[c] = !(fill_q[c] < k_len_q);
            wr_en[c]    = (state_q == S_COLLECT) && stream_mode && PE_bot_valid[c] && !col_full[c];
        end
        all_full     = &col_full;
        handshake    = (state_q == S_DRAIN) && stream_mode && Out_ready;
        last_beat    = handshake && (rd_idx_q == K_ADDR_LEN'(k_len_q - 1'b1));
        overflow_set = stream_mode &&
                       (((state_q == S_COLLECT) && |(PE_bot_valid & col_full)) ||
                        ((state_q == S_DRAIN) && |PE_bot_valid));
    end

    // Column RAMs are not reset
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            if (wr_en[c]) begin
                col_ram[c][fill_q[c]] <= PE_bot_data[c];
            end
        end
    end

    // Streaming FSM with fill, read and tile counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_len_q    <= '0;
            loop_num_q <= '0;
            rd_idx_q   <= '0;
            loop_cnt_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int unsigned c = 0; c < NUM_COLS; c++) fill_q[c] <= '0;
        end else begin
            done_q <= 1'b0;
            if (overflow_set) overflow_q <= 1'b1;
            if (!stream_mode) begin
                state_q    <= S_IDLE;
                rd_idx_q   <= '0;
                loop_cnt_q <= '0;
                for (int unsigned c = 0; c < NUM_COLS; c++) fill_q[c] <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if ((K_len != '0) && (Loop_num != '0)) begin
                            state_q    <= S_COLLECT;
                            k_len_q    <= K_len;
                            loop_num_q <= Loop_num;
                        end
                    end
                    S_COLLECT: begin
                        for (int unsigned c = 0; c < NUM_COLS; c++) begin
                            if (wr_en[c]) fill_q[c] <= fill_q[c] + 1'b1;
                        end
                        if (all_full) begin
                            state_q  <= S_DRAIN;
                            rd_idx_q <= '0;
                        end
                    end
                    S_DRAIN: begin
                        if (last_beat) begin
                            rd_idx_q <= '0;
                            for (int unsigned c = 0; c < NUM_COLS; c++) fill_q[c] <= '0;
                            if (LOOP_WIDTH'(loop_cnt_q + 1'b1) == loop_num_q) begin
                                done_q     <= 1'b1;
                                loop_cnt_q <= '0;
                                state_q    <= S_IDLE;
                            end else begin
                                loop_cnt_q <= loop_cnt_q + 1'b1;
                                state_q    <= S_COLLECT;
                            end
                        end else if (handshake) begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Output mux: drained RAM row, bypass, or idle zero
    always_comb begin
        Out_valid = 1'b0;
        Out_data  = '0;
        case (Mode)
            2'b00: begin
                if (state_q == S_DRAIN) begin
                    Out_valid = 1'b1;
                    for (int unsigned c = 0; c < NUM_COLS; c++) Out_data[c] = col_ram[c][rd_idx_q];
                end
            end
            2'b01, 2'b10: begin
                Out_valid = &PE_bot_valid;
                Out_data  = PE_bot_data;
            end
            default: ;
        endcase
    end

    assign streaming_drain_done = done_q;
    assign overflow_err         = overflow_q;

`ifdef OUTBUS_SKEW_CHECK_EN
    localparam int unsigned TW = 8;

    logic [TW-1:0] tcnt_q;
    logic          skew_q;
    logic          skew_hit;

    // tcnt_q counts cycles since column 0's first write of the tile
    always_comb begin
        skew_hit = 1'b0;
        for (int unsigned c = 1; c < NUM_COLS; c++) begin
            if (wr_en[c] && (fill_q[c] == '0) && ((fill_q[0] == '0) || (tcnt_q != TW'(c)))) begin
                skew_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            skew_q <= 1'b0;
        end else begin
            if (skew_hit) skew_q <= 1'b1;
            if (wr_en[0] && (fill_q[0] == '0)) begin
                tcnt_q <= TW'(1);
            end else if (tcnt_q != '1) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
        end
    end

    assign skew_err = skew_q;
`else
    assign skew_err = 1'b0;
`endif

endmodule

// File: tb/tb_bottom_output_bus.sv
// Scoreboard bench for bottom_output_bus: stimulus pushes expected beats, a monitor pops on handshake.
module tb_bottom_output_bus;
    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned NC    = 4;
    localparam int unsigned KA    = 7;
    localparam int unsigned LW    = 8;
    localparam int unsigned VW    = LANES * DW;

    typedef logic [NC-1:0][VW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    Mode;
    logic [KA-1:0] K_len;
    logic [LW-1:0] Loop_num;
    vec_t          PE_bot_data;
    logic [NC-1:0] PE_bot_valid;
    vec_t          Out_data;
    logic          Out_valid;
    logic          Out_ready;
    logic          streaming_drain_done;
    logic          overflow_err;
    logic          skew_err;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    bit   mon_en   = 1'b0;
    bit   hs_prev  = 1'b0;
    vec_t exp_q[$];

    bottom_output_bus #(
        .LANES(LANES), .DW(DW), .NUM_COLS(NC), .K_ADDR_LEN(KA), .LOOP_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .Mode(Mode), .K_len(K_len), .Loop_num(Loop_num),
        .PE_bot_data(PE_bot_data), .PE_bot_valid(PE_bot_valid),
        .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .streaming_drain_done(streaming_drain_done),
        .overflow_err(overflow_err), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NC*VW-1:0] act, input logic [NC*VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pat(input int c, input int r, input int tag);
        logic [VW-1:0] v;
        for (int l = 0; l < int'(LANES); l++) v[l*DW +: DW] = DW'((tag << 24) | (l << 16) | (c << 8) | r);
        return v;
    endfunction

    // Monitor: compare every presented beat with the queue head; pop on handshake
    always @(negedge clk) begin
        if (streaming_drain_done) begin
            done_cnt++;
            chk("done_after_last_beat", 1'(hs_prev), 1);
        end
        hs_prev = 1'b0;
        if (mon_en && Out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h with empty scoreboard", Out_data);
            end else begin
                chk("beat_data", Out_data, exp_q[0]);
                if (Out_ready) begin
                    void'(exp_q.pop_front());
                    hs_prev = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int k, input int loops);
        Mode     = 2'b00;
        K_len    = KA'(k);
        Loop_num = LW'(loops);
        tick();
        K_len    = '0;
        Loop_num = '0;
    endtask

    // Column c streams len rows starting at cycle c (+1 for skew_col); column 0 gets extra0 surplus beats
    task automatic fill_tile(input int k, input int tag, input int extra0, input int skew_col, input bit push);
        int   st[NC];
        int   ln[NC];
        int   tot = 0;
        vec_t e;
        for (int c = 0; c < int'(NC); c++) begin
            st[c] = c + ((c == skew_col) ? 1 : 0);
            ln[c] = k + ((c == 0) ? extra0 : 0);
            if (st[c] + ln[c] > tot) tot = st[c] + ln[c];
        end
        for (int t = 0; t < tot; t++) begin
            for (int c = 0; c < int'(NC); c++) begin
                PE_bot_valid[c] = (t >= st[c]) && (t < st[c] + ln[c]);
                PE_bot_data[c]  = PE_bot_valid[c] ? pat(c, t - st[c], tag) : '0;
            end
            tick();
            if (extra0 > 0 && t == st[0] + k - 1) chk("overflow_clear_before", 1'(overflow_err), 0);
            if (extra0 > 0 && t == st[0] + k)     chk("overflow_set", 1'(overflow_err), 1);
        end
        PE_bot_valid = '0;
        PE_bot_data  = '0;
        if (push) begin
            for (int r = 0; r < k; r++) begin
                for (int c = 0; c < int'(NC); c++) e[c] = pat(c, r, tag);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input bit bp);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            Out_ready = bp ? ~n[0] : 1'b1;
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats left, required 0", exp_q.size());
            exp_q.delete();
        end
        Out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t a5;
        int   d0;
        a5 = {(NC*VW/8){8'hA5}};

        rst_n        = 1'b0;
        Mode         = 2'b00;
        K_len        = '0;
        Loop_num     = '0;
        PE_bot_data  = '0;
        PE_bot_valid = '0;
        Out_ready    = 1'b1;
        #12;
        chk("reset_out_valid", 1'(Out_valid), 0);
        chk("reset_out_data", Out_data, 0);
        chk("reset_done", 1'(streaming_drain_done), 0);
        chk("reset_overflow", 1'(overflow_err), 0);
        chk("reset_skew", 1'(skew_err), 0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Normal job: two tiles of three rows, ready always high
        start_job(3, 2);
        fill_tile(3, 1, 0, -1, 1);
        chk("valid_low_after_last_write", 1'(Out_valid), 0);
        tick();
        chk("valid_rise_latency", 1'(Out_valid), 1);
        wait_drain(1'b0);
        chk("no_done_after_tile1", 32'(done_cnt), 0);
        fill_tile(3, 2, 0, -1, 1);
        wait_drain(1'b0);
        tick();
        tick();
        chk("done_count_normal", 32'(done_cnt), 1);
        chk("idle_after_job", 1'(Out_valid), 0);

        // Backpressure: ready alternates, beats held while ready is low
        start_job(3, 1);
        fill_tile(3, 3, 0, -1, 1);
        wait_drain(1'b1);
        tick();
        tick();
        chk("done_count_bp", 32'(done_cnt), 2);

        // Overflow: column 0 pushes a 4th beat into a 3-row tile
        start_job(3, 1);
        fill_tile(3, 4, 1, -1, 1);
        wait_drain(1'b0);
        tick();
        tick();
        chk("done_count_ovf", 32'(done_cnt), 3);
        chk("overflow_sticky", 1'(overflow_err), 1);

        // Abort after two rows, then a fresh job must drain cleanly
        d0 = done_cnt;
        start_job(3, 1);
        fill_tile(2, 5, 0, -1, 0);
        mon_en = 1'b0;
        Mode   = 2'b01;
        tick();
        chk("abort_bypass_valid", 1'(Out_valid), 0);
        Mode   = 2'b00;
        mon_en = 1'b1;
        tick();
        tick();
        chk("abort_no_drain", 1'(Out_valid), 0);
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        start_job(3, 1);
        fill_tile(3, 6, 0, -1, 1);
        wait_drain(1'b0);
        tick();
        tick();
        chk("done_count_after_abort", 32'(done_cnt), 32'(d0 + 1));

        // Bypass and reserved modes are combinational
        mon_en       = 1'b0;
        Out_ready    = 1'b0;
        Mode         = 2'b01;
        PE_bot_data  = a5;
        PE_bot_valid = 4'b1111;
        #1;
        chk("bypass01_valid", 1'(Out_valid), 1);
        chk("bypass01_data", Out_data, a5);
        PE_bot_valid = 4'b0111;
        #1;
        chk("bypass01_partial_valid", 1'(Out_valid), 0);
        Mode         = 2'b10;
        PE_bot_valid = 4'b1111;
        #1;
        chk("bypass10_valid", 1'(Out_valid), 1);
        chk("bypass10_data", Out_data, a5);
        Mode = 2'b11;
        #1;
        chk("mode11_valid", 1'(Out_valid), 0);
        chk("mode11_data", Out_data, 0);
        tick();
        PE_bot_valid = '0;
        PE_bot_data  = '0;
        Mode         = 2'b00;
        Out_ready    = 1'b1;
        tick();
        chk("bypass_no_done", 32'(done_cnt), 32'(d0 + 1));
        mon_en = 1'b1;

`ifdef OUTBUS_SKEW_CHECK_EN
        // Column 2 arrives one cycle late: flagged, data still intact
        chk("skew_clear_before", 1'(skew_err), 0);
        start_job(3, 1);
        fill_tile(3, 7, 0, 2, 1);
        chk("skew_set", 1'(skew_err), 1);
        wait_drain(1'b0);
        tick();
        tick();
        chk("done_count_skew", 32'(done_cnt), 32'(d0 + 2));
`else
        chk("skew_tied_low", 1'(skew_err), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
